// File: rtl/vga_capture_pkg.sv
// Shared constants, types and helpers for the VGA frame capture block.
package vga_capture_pkg;

  // Default 640x480@60 timing and capture window
  localparam int unsigned H_BP_DEF  = 144;
  localparam int unsigned V_BP_DEF  = 31;
  localparam int unsigned IMG_W_DEF = 160;
  localparam int unsigned IMG_H_DEF = 120;

  // Counter / address width and input colour depth
  localparam int unsigned CNT_W = 16;
  localparam int unsigned COL_W = 3;

  // CRC-16-CCITT
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Widen a 3-bit channel to 8 bits by bit replication
  function automatic logic [7:0] expand3(input logic [COL_W-1:0] c);
    return {c, c, c[2:1]};
  endfunction

  // Advance a CRC-16-CCITT over one 24-bit word, MSB first
  function automatic logic [15:0] crc16_upd(input logic [15:0] crc_in, input logic [23:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 23; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = 16'(c << 1) ^ CRC_POLY;
      else                 c = 16'(c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_sync_tracker.sv
// Registers the VGA syncs, flags their falling edges and keeps pixel/line counters.
module vga_sync_tracker
  import vga_capture_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             pix_en,
  output logic             vs_fall_c,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt
);

  logic             hsync_q, hsync_d;
  logic             hsync_prev_q, hsync_prev_d;
  logic             vsync_q, vsync_d;
  logic             vsync_prev_q, vsync_prev_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;
  logic             hs_fall_c;

  // Edges are taken between the registered copy and its previous value
  assign hs_fall_c = hsync_prev_q & ~hsync_q;
  assign vs_fall_c = vsync_prev_q & ~vsync_q;

  // Next-state for sync pipeline and counters; clear has priority over count
  always_comb begin
    hsync_d      = hsync;
    vsync_d      = vsync;
    hsync_prev_d = hsync_q;
    vsync_prev_d = vsync_q;
    hcnt_d       = hcnt_q;
    vcnt_d       = vcnt_q;
    if (hs_fall_c)   hcnt_d = '0;
    else if (pix_en) hcnt_d = hcnt_q + CNT_W'(1);
    if (vs_fall_c)      vcnt_d = '0;
    else if (hs_fall_c) vcnt_d = vcnt_q + CNT_W'(1);
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q      <= 1'b0;
      hsync_prev_q <= 1'b0;
      vsync_q      <= 1'b0;
      vsync_prev_q <= 1'b0;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
    end else begin
      hsync_q      <= hsync_d;
      hsync_prev_q <= hsync_prev_d;
      vsync_q      <= vsync_d;
      vsync_prev_q <= vsync_prev_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
    end
  end

  assign hcnt = hcnt_q;
  assign vcnt = vcnt_q;

endmodule

// File: rtl/vga_frame_capture.sv
// Captures one windowed VGA frame per arm request into a frame buffer.
// Optional: define CAPTURE_CRC_EN to add a running CRC-16-CCITT over written pixels.
module vga_frame_capture
  import vga_capture_pkg::*;
#(
  parameter int unsigned H_BP  = H_BP_DEF,
  parameter int unsigned V_BP  = V_BP_DEF,
  parameter int unsigned X0    = 0,
  parameter int unsigned Y0    = 0,
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             pix_en,
  input  logic [COL_W-1:0] red,
  input  logic [COL_W-1:0] green,
  input  logic [COL_W-1:0] blue,
  input  logic             arm,
  output logic             wr_en,
  output logic [15:0]      wr_addr,
  output logic [23:0]      wr_data,
  output logic             busy,
  output logic             done,
  output logic             frame_err,
  output logic [15:0]      crc
);

  localparam int unsigned      NPIX     = IMG_W * IMG_H;
  localparam logic [CNT_W-1:0] H_LO     = CNT_W'(H_BP + X0);
  localparam logic [CNT_W-1:0] H_HI     = CNT_W'(H_BP + X0 + IMG_W);
  localparam logic [CNT_W-1:0] V_LO     = CNT_W'(V_BP + Y0);
  localparam logic [CNT_W-1:0] V_HI     = CNT_W'(V_BP + Y0 + IMG_H);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NPIX - 1);

  logic             vs_fall_c;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;
  logic             in_win_c;

  cap_state_e       state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             wr_en_q, wr_en_d;
  logic [15:0]      wr_addr_q, wr_addr_d;
  rgb888_t          wr_data_q, wr_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             frame_err_q, frame_err_d;

  vga_sync_tracker u_sync (
    .clk       (clk),
    .rst       (rst),
    .hsync     (hsync),
    .vsync     (vsync),
    .pix_en    (pix_en),
    .vs_fall_c (vs_fall_c),
    .hcnt      (hcnt),
    .vcnt      (vcnt)
  );

  // Current pixel lies inside the capture window
  assign in_win_c = pix_en && (hcnt >= H_LO) && (hcnt < H_HI) &&
                    (vcnt >= V_LO) && (vcnt < V_HI);

  // Capture FSM next-state and registered-output values
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = frame_err_q;
    case (state_q)
      ST_IDLE: begin
        // A coinciding vsync fall is deliberately not acted on here
        if (arm) begin
          state_d     = ST_ARMED;
          frame_err_d = 1'b0;
        end
      end
      ST_ARMED: begin
        if (vs_fall_c) begin
          state_d = ST_CAPTURE;
          wcnt_d  = '0;
        end
      end
      ST_CAPTURE: begin
        if (vs_fall_c) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end else if (in_win_c) begin
          wr_en_d   = 1'b1;
          wr_addr_d = 16'(wcnt_q);
          wr_data_d = '{r: expand3(red), g: expand3(green), b: expand3(blue)};
          wcnt_d    = wcnt_q + CNT_W'(1);
          if (wcnt_q == LAST_IDX) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (arm) begin
          state_d     = ST_ARMED;
          frame_err_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
    done_d = (state_d == ST_DONE);
  end

  // FSM and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_err = frame_err_q;

`ifdef CAPTURE_CRC_EN
  logic [15:0] crc_q, crc_d;

  // Seed at capture start, fold in every written pixel, hold otherwise
  always_comb begin
    crc_d = crc_q;
    if ((state_q == ST_ARMED) && vs_fall_c) crc_d = CRC_INIT;
    else if (wr_en_d)                        crc_d = crc16_upd(crc_q, wr_data_d);
  end

  // CRC register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_q <= 16'h0000;
    else     crc_q <= crc_d;
  end

  assign crc = crc_q;
`else
  assign crc = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_frame_capture.sv
// Randomized bench for vga_frame_capture against a behavioural frame model.
// Uses a reduced raster (40x30 pixels, 16x10 window) to keep runs short.
module tb_vga_frame_capture;

  localparam int H_BP  = 8;
  localparam int V_BP  = 4;
  localparam int X0    = 3;
  localparam int Y0    = 2;
  localparam int IMG_W = 16;
  localparam int IMG_H = 10;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int H_TOT = 40;
  localparam int HS_W  = 4;
  localparam int V_TOT = 30;
  localparam int VS_W  = 2;

  localparam int M_IDLE = 0, M_ARMED = 1, M_CAP = 2, M_DONE = 3;

  logic        clk = 1'b0;
  logic        rst, hsync, vsync, pix_en, arm;
  logic [2:0]  red, green, blue;
  logic        wr_en, busy, done, frame_err;
  logic [15:0] wr_addr, crc;
  logic [23:0] wr_data;

  always #5 clk = ~clk;

  vga_frame_capture #(
    .H_BP(H_BP), .V_BP(V_BP), .X0(X0), .Y0(Y0), .IMG_W(IMG_W), .IMG_H(IMG_H)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .pix_en(pix_en),
    .red(red), .green(green), .blue(blue), .arm(arm),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .frame_err(frame_err), .crc(crc)
  );

  int total = 0;
  int bad   = 0;

  // Model state
  int          m_st, m_cnt, m_h, m_v;
  bit          m_hs, m_hs_p, m_vs, m_vs_p;
  bit          e_wr, e_err;
  int          e_addr;
  logic [23:0] e_data;
  logic [15:0] m_crc;

  // Per-frame statistics
  int fr_wr, fr_last, wr_after_err, cur_mode;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] x8(input logic [2:0] c);
    return 8'(c * 36 + c / 2);
  endfunction

  function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    c = c_in ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) c = c[15] ? (16'(c << 1) ^ 16'h1021) : 16'(c << 1);
    return c;
  endfunction

  function automatic logic [15:0] exp_crc();
`ifdef CAPTURE_CRC_EN
    return m_crc;
`else
    return 16'h0000;
`endif
  endfunction

  // Advance the model by the clock edge that just happened
  task automatic model_step();
    bit hf, vf, inwin;
    if (rst) begin
      m_st = M_IDLE; m_cnt = 0; m_h = 0; m_v = 0;
      m_hs = 0; m_hs_p = 0; m_vs = 0; m_vs_p = 0;
      e_wr = 0; e_err = 0; e_addr = 0; e_data = '0; m_crc = 16'h0000;
      return;
    end
    hf = m_hs_p && !m_hs;
    vf = m_vs_p && !m_vs;
    inwin = pix_en && (m_h >= H_BP + X0) && (m_h < H_BP + X0 + IMG_W) &&
            (m_v >= V_BP + Y0) && (m_v < V_BP + Y0 + IMG_H);
    e_wr = 0;
    case (m_st)
      M_IDLE, M_DONE: if (arm) begin m_st = M_ARMED; e_err = 0; end
      M_ARMED: if (vf) begin m_st = M_CAP; m_cnt = 0; m_crc = 16'hFFFF; end
      default: begin
        if (vf) begin
          m_st = M_IDLE; e_err = 1;
        end else if (inwin) begin
          e_wr   = 1;
          e_addr = m_cnt;
          e_data = {x8(red), x8(green), x8(blue)};
          m_crc  = crc_byte(crc_byte(crc_byte(m_crc, e_data[23:16]), e_data[15:8]), e_data[7:0]);
          m_cnt++;
          if (m_cnt == NPIX) m_st = M_DONE;
        end
      end
    endcase
    m_h = hf ? 0 : (pix_en ? m_h + 1 : m_h);
    m_v = vf ? 0 : (hf ? m_v + 1 : m_v);
    m_hs_p = m_hs; m_hs = hsync;
    m_vs_p = m_vs; m_vs = vsync;
  endtask

  // One cycle: sample at negedge, compare against the model
  task automatic step();
    @(negedge clk);
    model_step();
    check_eq("wr_en", 32'(wr_en), 32'(e_wr));
    if (e_wr) begin
      check_eq("wr_addr", 32'(wr_addr), 32'(e_addr));
      check_eq("wr_data", 32'(wr_data), 32'(e_data));
    end
    check_eq("busy", 32'(busy), 32'(m_st == M_ARMED || m_st == M_CAP));
    check_eq("done", 32'(done), 32'(m_st == M_DONE));
    check_eq("frame_err", 32'(frame_err), 32'(e_err));
    check_eq("crc", 32'(crc), 32'(exp_crc()));
    if (wr_en) begin
      fr_wr++;
      fr_last = int'(wr_addr);
      if (frame_err) wr_after_err++;
      if (cur_mode == 0) check_eq("solid_data", 32'(wr_data), 32'(24'hB6B6B6));
      if (cur_mode == 1 && (int'(wr_addr) % IMG_W) == 0)
        check_eq("row_start_red", 32'(wr_data[23:16]), 32'(x8(3'((H_BP + X0) % 8))));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    check_eq({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check_eq({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check_eq({tag, "_crc"}, 32'(crc), 32'd0);
  endtask

  // Drive one raster frame; arm_at=-2 pulses arm on the cycle the vsync fall is acted on
  task automatic run_frame(input int v_tot, input int mode, input int gap, input int arm_at,
                           input int rst_at, input bit spam);
    int cyc;
    int p;
    cyc = 0;
    fr_wr = 0;
    cur_mode = mode;
    for (int ln = 0; ln < v_tot; ln++) begin
      p = 0;
      while (p < H_TOT) begin
        step();
        rst = 1'b0;
        arm = 1'b0;
        if (cyc == arm_at) arm = 1'b1;
        if (arm_at == -2 && m_vs_p && !m_vs) arm = 1'b1;
        if (spam && (m_st == M_ARMED || m_st == M_CAP) && $urandom_range(19) == 0) arm = 1'b1;
        hsync  = (p < HS_W) ? 1'b0 : 1'b1;
        vsync  = (ln < VS_W) ? 1'b0 : 1'b1;
        pix_en = (int'($urandom_range(99)) >= gap);
        case (mode)
          0: begin red = 3'b101; green = 3'b101; blue = 3'b101; end
          1: begin red = 3'(m_h); green = 3'($urandom); blue = 3'($urandom); end
          2: begin red = 3'($urandom); green = 3'($urandom); blue = 3'($urandom); end
          default: begin red = 3'd0; green = 3'd0; blue = 3'd0; end
        endcase
        if (cyc == rst_at) begin
          rst = 1'b1;
          #1;
          check_all_zero("async_rst");
        end
        if (pix_en) p++;
        cyc++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; hsync = 1'b1; vsync = 1'b1; pix_en = 1'b0; arm = 1'b0;
    red = 3'd0; green = 3'd0; blue = 3'd0;
    fr_wr = 0; fr_last = 0; wr_after_err = 0; cur_mode = 2;
    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b0;

    // No arm: nothing captured
    run_frame(V_TOT, 2, 0, -1, -1, 1'b0);
    check_eq("idle_writes", 32'(fr_wr), 32'd0);

    // Arm, then a solid 3'b101 frame
    run_frame(V_TOT, 2, 0, 100, -1, 1'b0);
    check_eq("armed_busy", 32'(busy), 32'd1);
    check_eq("armed_writes", 32'(fr_wr), 32'd0);
    run_frame(V_TOT, 0, 0, -1, -1, 1'b0);
    check_eq("solid_count", 32'(fr_wr), 32'(NPIX));
    check_eq("solid_last_addr", 32'(fr_last), 32'(NPIX - 1));
    check_eq("solid_done", 32'(done), 32'd1);
    check_eq("solid_busy", 32'(busy), 32'd0);

    // Arm in DONE, gradient capture with gaps and repeated arms while busy
    run_frame(V_TOT, 2, 0, 50, -1, 1'b1);
    check_eq("rearm_done_clr", 32'(done), 32'd0);
    run_frame(V_TOT, 1, 25, -1, -1, 1'b1);
    check_eq("grad_count", 32'(fr_wr), 32'(NPIX));
    check_eq("grad_done", 32'(done), 32'd1);

    // Short frame: vsync falls again mid-window
    run_frame(V_TOT, 2, 0, 10, -1, 1'b0);
    run_frame(10, 2, 10, -1, -1, 1'b0);
    check_eq("abort_partial", 32'(fr_wr > 0 && fr_wr < NPIX), 32'd1);
    run_frame(V_TOT, 2, 0, -1, -1, 1'b0);
    check_eq("abort_err", 32'(frame_err), 32'd1);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_writes", 32'(fr_wr), 32'd0);
    check_eq("writes_after_err", 32'(wr_after_err), 32'd0);

    // Arm coinciding with vsync fall in IDLE only arms
    run_frame(V_TOT, 2, 0, -2, -1, 1'b0);
    check_eq("coinc_writes", 32'(fr_wr), 32'd0);
    check_eq("coinc_busy", 32'(busy), 32'd1);
    check_eq("coinc_err_clr", 32'(frame_err), 32'd0);
    run_frame(V_TOT, 2, 20, -1, -1, 1'b1);
    check_eq("rand_count", 32'(fr_wr), 32'(NPIX));

    // Reset in the middle of a capture, then a clean all-zero capture
    run_frame(V_TOT, 2, 0, 10, -1, 1'b0);
    run_frame(V_TOT, 2, 0, -1, 8 * H_TOT, 1'b0);
    check_eq("rst_partial", 32'(fr_wr > 0 && fr_wr < NPIX), 32'd1);
    check_eq("rst_no_err", 32'(frame_err), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    run_frame(V_TOT, 2, 0, 10, -1, 1'b0);
    run_frame(V_TOT, 3, 15, -1, -1, 1'b0);
    check_eq("zero_count", 32'(fr_wr), 32'(NPIX));
    check_eq("zero_done", 32'(done), 32'd1);
    check_eq("crc_final", 32'(crc), 32'(exp_crc()));
    run_frame(V_TOT, 2, 0, -1, -1, 1'b0);
    check_eq("crc_held", 32'(crc), 32'(exp_crc()));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_frame_capture.md
VGA_FRAME_CAPTURE -- requirements
Module: vga_frame_capture

Interface
REQ-001 SHALL have parameter H_BP, default 144, meaning hsync-fall to first active pixel, in pixels.
REQ-002 SHALL have parameter V_BP, default 31, meaning vsync-fall to first active line, in lines.
REQ-003 SHALL have parameter X0, default 0, meaning capture window column offset within the active area.
REQ-004 SHALL have parameter Y0, default 0, meaning capture window row offset within the active area.
REQ-005 SHALL have parameter IMG_W, default 160, meaning capture window width in pixels.
REQ-006 SHALL have parameter IMG_H, default 120, meaning capture window height in lines; IMG_W*IMG_H SHALL be at most 65536.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all inputs are synchronous to it.
REQ-008 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have ports hsync and vsync, input, 1 bit each: active-low VGA syncs.
REQ-010 SHALL have port pix_en, input, 1 bit: pixel strobe, one cycle per pixel.
REQ-011 SHALL have ports red, green and blue, input, 3 bits each: the pixel colour.
REQ-012 SHALL have port arm, input, 1 bit: a one-cycle request to capture the next frame.
REQ-013 SHALL have port wr_en, output, 1 bit: frame-buffer write strobe.
REQ-014 SHALL have port wr_addr, output, 16 bits: frame-buffer address.
REQ-015 SHALL have port wr_data, output, 24 bits: {R8,G8,B8}.
REQ-016 SHALL have ports busy, done and frame_err, output, 1 bit each: status.
REQ-017 SHALL have port crc, output, 16 bits: frame checksum (see Configuration).

Function
REQ-018 SHALL register hsync/vsync once and detect falling edges on the registered copies.
REQ-019 SHALL clear hcnt on hsync fall and otherwise increment hcnt on pix_en; SHALL clear vcnt on vsync fall and otherwise increment vcnt on hsync fall.
REQ-020 SHALL treat a pixel as in-window when hcnt is in [H_BP+X0, H_BP+X0+IMG_W) and vcnt is in [V_BP+Y0, V_BP+Y0+IMG_H), qualified by pix_en.
REQ-021 SHALL use FSM IDLE -> ARMED on arm; ARMED -> CAPTURE on vsync fall; CAPTURE -> DONE after write number IMG_W*IMG_H; DONE -> ARMED on arm.
REQ-022 SHALL, in CAPTURE, assert wr_en exactly one cycle after each in-window pix_en, with pixel latency of 1 clk.
REQ-023 SHALL start wr_addr at 0 per frame and increment it by 1 per write; it SHALL never wrap within a frame.
REQ-024 SHALL expand each channel by bit replication: c8 = {c,c,c[2:1]}, so 3'b111 -> 8'hFF and 3'b000 -> 8'h00.
REQ-025 SHALL, on vsync fall in CAPTURE before the final write, set sticky frame_err, abort to IDLE, and issue no further writes.
REQ-026 SHALL ignore arm in ARMED and CAPTURE; arm in IDLE or DONE SHALL clear done and frame_err.
REQ-027 SHALL assert busy in ARMED and CAPTURE, and assert done in DONE only.
REQ-028 SHALL, when a vsync fall and arm coincide in IDLE, only arm and not start capture until the next vsync fall.

Reset
REQ-029 SHALL, on rst, go to IDLE and drive all outputs to 0 (crc 16'h0000), with hcnt, vcnt, wr_addr and the edge registers cleared; a capture in progress SHALL be dropped without error.

Configuration
REQ-030 SHALL, with CAPTURE_CRC_EN defined, update crc on each write as CRC-16-CCITT (poly 16'h1021, init 16'hFFFF at CAPTURE entry) over wr_data MSB first, final value held in DONE.
REQ-031 SHALL, without CAPTURE_CRC_EN, tie crc to 16'h0000 and synthesise no CRC logic.

Structure
REQ-032 SHALL take the default timing constants, the FSM state encoding and the CRC polynomial/init from shared package vga_capture_pkg.
REQ-033 SHALL place hsync/vsync edge detection and hcnt/vcnt in one sub-module, vga_sync_tracker.

Verification
REQ-034 SHALL verify: 800x521 timing, pix_en=1, arm, solid colour 3'b101 -> 19200 writes, addr 0..19199, data 24'hB6B6B6, then done=1 and busy=0.
REQ-035 SHALL verify: gradient red=hcnt[2:0] -> first write of each row carries R8 for (H_BP+X0)[2:0], with row stride 160 addresses.
REQ-036 SHALL verify: vsync fall at vcnt 60 during CAPTURE -> frame_err=1, state IDLE, no wr_en afterwards.
REQ-037 SHALL verify: rst pulse mid-CAPTURE -> all outputs 0 within one cycle, and a fresh arm and frame then captures normally.
REQ-038 SHALL verify: arm repeated while busy -> ignored; arm in DONE -> done clears and the next frame is captured.
REQ-039 SHALL verify: CAPTURE_CRC_EN with all-zero frame -> crc matches the reference model; without the macro -> crc=0.
